// File: rtl/popcount_pkg.sv
// Shared types and sizing helpers for the sequential population counter.
package popcount_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to hold any count from 0 to w inclusive.
    function automatic int count_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/popcount_chunk.sv
// Combinational ones-count of a STEP-bit slice.
module popcount_chunk #(
    parameter int STEP = 1
) (
    input  logic [STEP-1:0]              bits,
    output logic [$clog2(STEP+1)-1:0]    ones
);
    localparam int OW = $clog2(STEP + 1);

    always_comb begin
        ones = '0;
        for (int i = 0; i < STEP; i++) begin
            ones = ones + OW'(bits[i]);
        end
    end

endmodule

// File: rtl/popcount_seq.sv
// Sequential population counter: consumes STEP operand bits per cycle and
// stops early once the remaining shift register is empty.
module popcount_seq
    import popcount_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [WIDTH-1:0]              data_in,
    input  logic                          count_zeros,
    output logic                          busy,
    output logic                          done,
    output logic [count_width(WIDTH)-1:0] count
);
    localparam int CW = count_width(WIDTH);

    state_t                      state, next_state;
    logic [WIDTH-1:0]            a, next_a;
    logic [CW-1:0]               next_count;
    logic [$clog2(STEP+1)-1:0]   chunk_ones;

    popcount_chunk #(.STEP(STEP)) u_chunk (
        .bits (a[STEP-1:0]),
        .ones (chunk_ones)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            a     <= '0;
            count <= '0;
        end else begin
            state <= next_state;
            a     <= next_a;
            count <= next_count;
        end
    end

    // Counting zeros is done by inverting on load so RUN only ever counts ones.
    always_comb begin
        next_state = state;
        next_a     = a;
        next_count = count;
        case (state)
            IDLE: begin
                if (start) begin
                    next_a     = count_zeros ? ~data_in : data_in;
                    next_count = '0;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (a != '0) begin
                    next_count = count + CW'(chunk_ones);
                    next_a     = a >> STEP;
                end else begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (!start) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_popcount_seq.sv
// Bench for popcount_seq: directed table, reset/start corner cases, and
// randomized operands against a spec-level reference model.
module tb_popcount_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_a, start_b;
    logic [7:0] data_a, data_b;
    logic       cz_a, cz_b;
    logic       busy_a, busy_b, done_a, done_b;
    logic [3:0] count_a, count_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    popcount_seq #(.WIDTH(8), .STEP(1)) u_s1 (
        .clk(clk), .reset(reset), .start(start_a), .data_in(data_a),
        .count_zeros(cz_a), .busy(busy_a), .done(done_a), .count(count_a)
    );

    popcount_seq #(.WIDTH(8), .STEP(2)) u_s2 (
        .clk(clk), .reset(reset), .start(start_b), .data_in(data_b),
        .count_zeros(cz_b), .busy(busy_b), .done(done_b), .count(count_b)
    );

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic       cz;
        int         exp_cycles;
        int         exp_count;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic sel_busy(input int sel);
        return (sel == 0) ? busy_a : busy_b;
    endfunction

    function automatic logic sel_done(input int sel);
        return (sel == 0) ? done_a : done_b;
    endfunction

    function automatic int sel_count(input int sel);
        return (sel == 0) ? int'(count_a) : int'(count_b);
    endfunction

    task automatic set_start(input int sel, input logic s);
        if (sel == 0) start_a = s; else start_b = s;
    endtask

    // Reference: cycles from the highest set bit of the loaded operand.
    function automatic int ref_cycles(input logic [7:0] d, input logic cz, input int step);
        logic [7:0] v;
        int m;
        v = cz ? ~d : d;
        if (v == 8'h00) return 1;
        m = 0;
        for (int i = 0; i < 8; i++) if (v[i]) m = i;
        return (m + 1 + step - 1) / step + 1;
    endfunction

    function automatic int ref_count(input logic [7:0] d, input logic cz);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) if (d[i] != cz) n++;
        return n;
    endfunction

    // Start an op, measure RUN length, check result and DONE hold, release.
    task automatic do_op(input int sel, input logic [7:0] d, input logic cz,
                         input int exp_cycles, input int exp_count, input string tag);
        int cycles;
        @(posedge clk); #1;
        if (sel == 0) begin data_a = d; cz_a = cz; end
        else          begin data_b = d; cz_b = cz; end
        set_start(sel, 1'b1);
        @(posedge clk);
        @(negedge clk);
        cycles = 0;
        while (sel_busy(sel) && cycles < 64) begin
            cycles++;
            @(negedge clk);
        end
        check({tag, "_cycles"}, cycles, exp_cycles);
        check({tag, "_done"}, int'(sel_done(sel)), 1);
        check({tag, "_count"}, sel_count(sel), exp_count);
        @(negedge clk);
        @(negedge clk);
        check({tag, "_hold"}, sel_count(sel) + 100 * int'(sel_done(sel)), exp_count + 100);
        set_start(sel, 1'b0);
        @(negedge clk);
        check({tag, "_idle"}, int'(sel_done(sel)) + 2 * int'(sel_busy(sel)), 0);
    endtask

    initial begin
        vec_t tbl[8];
        int cycles;
        logic [7:0] d;
        logic cz;
        int sel;

        tbl[0] = '{0, 8'hB5, 1'b0, 9, 5};
        tbl[1] = '{0, 8'h00, 1'b0, 1, 0};
        tbl[2] = '{0, 8'hF0, 1'b1, 5, 4};
        tbl[3] = '{1, 8'hFF, 1'b0, 5, 8};
        tbl[4] = '{0, 8'h01, 1'b0, 2, 1};
        tbl[5] = '{1, 8'h80, 1'b0, 5, 1};
        tbl[6] = '{0, 8'h00, 1'b1, 9, 8};
        tbl[7] = '{1, 8'h03, 1'b0, 2, 2};

        reset = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        data_a = '0; data_b = '0; cz_a = 1'b0; cz_b = 1'b0;
        #12;
        check("rst_a", int'(busy_a) + 2 * int'(done_a) + 4 * int'(count_a), 0);
        check("rst_b", int'(busy_b) + 2 * int'(done_b) + 4 * int'(count_b), 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++)
            do_op(tbl[i].sel, tbl[i].data, tbl[i].cz, tbl[i].exp_cycles,
                  tbl[i].exp_count, $sformatf("vec%0d", i));

        // Reset mid-RUN must clear outputs without waiting for a clock edge.
        @(posedge clk); #1;
        data_a = 8'hB5; cz_a = 1'b0; start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_busy", int'(busy_a), 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst", int'(busy_a) + 2 * int'(done_a) + 4 * int'(count_a), 0);
        start_a = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        do_op(0, 8'h03, 1'b0, 3, 2, "after_rst");

        // Dropping start during RUN must not abort; DONE then lasts one cycle.
        @(posedge clk); #1;
        data_a = 8'h81; cz_a = 1'b0; start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cycles = 1;
        @(negedge clk);
        cycles++;
        start_a = 1'b0;
        @(negedge clk);
        while (busy_a && cycles < 64) begin
            cycles++;
            @(negedge clk);
        end
        check("drop_cycles", cycles, 9);
        check("drop_done", int'(done_a), 1);
        check("drop_count", int'(count_a), 2);
        @(negedge clk);
        check("drop_idle", int'(done_a) + 2 * int'(busy_a), 0);

        for (int i = 0; i < 24; i++) begin
            d   = 8'($urandom);
            cz  = 1'($urandom);
            sel = i % 2;
            do_op(sel, d, cz, ref_cycles(d, cz, sel + 1), ref_count(d, cz),
                  $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/popcount_seq.md
POPCOUNT_SEQ -- requirements
Module: popcount_seq

Interface
REQ-001 Parameter WIDTH, 16, operand width in bits; SHALL be >= 2.
REQ-002 Parameter STEP, 1, operand bits consumed per RUN cycle; SHALL be >= 1 and SHALL divide WIDTH.
REQ-003 Localparam CW SHALL equal $clog2(WIDTH+1), the count width.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  level request; sampled in IDLE, held by the requester until done.
REQ-007 data_in  input  WIDTH  operand; sampled only on the IDLE-to-RUN edge.
REQ-008 count_zeros  input  1  0 = count ones, 1 = count zeros; sampled with data_in.
REQ-009 busy  output  1  high while in RUN.
REQ-010 done  output  1  high while in DONE.
REQ-011 count  output  CW  result register; valid while done = 1.

Function
REQ-012 The block SHALL implement a three-state FSM (IDLE, RUN, DONE) with a registered state.
REQ-013 busy and done SHALL be decoded from the state only, never from inputs.
REQ-014 IDLE with start = 0: the block SHALL stay in IDLE and hold count.
REQ-015 IDLE with start = 1: the block SHALL load shift register A from data_in (bitwise inverted when count_zeros = 1), clear count to 0, and enter RUN.
REQ-016 RUN with A != 0: count SHALL increase by the number of ones in A[STEP-1:0]; A SHALL shift right by STEP with zero fill; the block SHALL stay in RUN.
REQ-017 RUN with A == 0: the block SHALL enter DONE with count unchanged (early termination).
REQ-018 RUN cycles SHALL equal ceil((m+1)/STEP)+1, where m is the index of the highest set bit of the loaded A; a zero A SHALL take 1 RUN cycle.
REQ-019 start SHALL be ignored during RUN; deasserting it SHALL NOT abort the operation.
REQ-020 DONE with start = 1: the block SHALL stay in DONE and hold count.
REQ-021 DONE with start = 0: the block SHALL return to IDLE on the next edge; done SHALL be high for at least one cycle.
REQ-022 The count adder SHALL be CW bits wide and SHALL NOT overflow; the maximum result is WIDTH.
REQ-023 An unreachable state encoding SHALL return to IDLE on the next edge, with busy = 0 and done = 0.

Reset
REQ-024 reset SHALL force the state to IDLE, A to 0, and count to 0, with busy = 0 and done = 0, immediately and independently of clk.
REQ-025 reset asserted during RUN or DONE SHALL discard the operation; the first start after reset release SHALL begin a fresh operation.

Structure
REQ-026 A shared package popcount_pkg SHALL hold the state enumeration (IDLE, RUN, DONE) and the count-width function.
REQ-027 A combinational sub-module popcount_chunk SHALL return the ones-count of STEP bits at width $clog2(STEP+1); popcount_seq SHALL instantiate it once.

Verification
REQ-028 WIDTH=8, STEP=1, data_in=0xB5, count_zeros=0, start held high -> busy for 9 cycles, then done=1 with count=5 held while start stays high.
REQ-029 WIDTH=8, STEP=1, data_in=0x00 -> 1 RUN cycle, then done=1 with count=0.
REQ-030 WIDTH=8, STEP=1, data_in=0xF0, count_zeros=1 -> A loads 0x0F, busy for 5 cycles, then count=4.
REQ-031 WIDTH=8, STEP=2, data_in=0xFF -> busy for 5 cycles, then count=8; start dropped in DONE -> IDLE next edge, done=0.
REQ-032 reset pulsed in the 3rd RUN cycle of 0xB5 -> busy=0, done=0, count=0 immediately; a new start with 0x03 -> count=2.
REQ-033 start deasserted in the 2nd RUN cycle of 0x81 -> RUN completes, done high for exactly 1 cycle with count=2, then IDLE.
